// File: rtl/mainfsm.sv
// mainfsm -- multicycle RISC-V main control FSM.
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback steps, driving the datapath mux selects, write enables and the
// 2-bit ALUOp consumed by the ALU decoder. A memory-ready handshake stalls
// the fetch, memory-read and memory-write states.
//
// Parameters:
//   MEMWAIT_EN  1: MemReady stalls memory states; 0: MemReady treated as 1.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, forces Fetch
//   op         in   [6:0] opcode field from the instruction register
//   Zero       in   ALU zero flag (qualifies beq)
//   MemReady   in   memory access completes this cycle
//   State      out  [3:0] current state encoding (debug)
//   AdrSrc     out  memory address select: 0 = PC, 1 = ALU result
//   IRWrite    out  load instruction register
//   ALUSrcA    out  [1:0] 00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB    out  [1:0] 00 = rs2, 01 = imm, 10 = 4
//   ResultSrc  out  [1:0] 00 = ALUOut, 01 = ReadData, 10 = ALUResult
//   ALUOp      out  [1:0] 00 = add, 01 = sub, 11 = funct decode
//   RegWrite   out  register file write
//   MemWrite   out  data memory write
//   PCWrite    out  PC load = PCUpdate | (Branch & Zero)
//   IllegalOp  out  one-cycle pulse on an unsupported opcode
//   InstrDone  out  one-cycle pulse on the final cycle of each instruction

module mainfsm #(
    parameter bit MEMWAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [3:0] State,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCWrite,
    output logic       IllegalOp,
    output logic       InstrDone
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q;
    state_t state_d;

    logic mem_ready;
    logic pc_update;
    logic branch;

    // With the wait handshake disabled every memory access completes at once.
    assign mem_ready = MEMWAIT_EN ? MemReady : 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR, S_EXECI, S_JAL: begin
                state_d = S_ALUWB;
            end
            S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
            end
            // Codes 11..15 are unreachable; recover to Fetch.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode. Everything is a Moore decode of state_q except the
    // MemReady-qualified fetch strobes, the S5 InstrDone and IllegalOp.
    always_comb begin
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IllegalOp = 1'b0;
        InstrDone = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_IALU, OP_JAL, OP_BEQ: begin
                        IllegalOp = 1'b0;
                    end
                    default: begin
                        IllegalOp = 1'b1;
                        InstrDone = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                // Write strobe is held through stalls; done only on release.
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b11;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                branch    = 1'b1;
                InstrDone = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm -- directed self-checking bench for mainfsm.
// Each cycle the inputs are set just after the rising edge, then State and
// the packed control vector are compared against hand-computed values.

module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic [3:0] State;
    logic       AdrSrc;
    logic       IRWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       IllegalOp;
    logic       InstrDone;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mainfsm #(.MEMWAIT_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .State     (State),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .PCWrite   (PCWrite),
        .IllegalOp (IllegalOp),
        .InstrDone (InstrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control outputs in a fixed field order (see c()).
    logic [14:0] ctrl;
    assign ctrl = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
                   RegWrite, MemWrite, PCWrite, IllegalOp, InstrDone};

    // Builds an expected control vector from individual fields.
    function automatic logic [14:0] c(
        input logic adr, input logic irw, input logic [1:0] asa,
        input logic [1:0] asb, input logic [1:0] rs, input logic [1:0] aop,
        input logic rw, input logic mw, input logic pcw, input logic ill,
        input logic done);
        return {adr, irw, asa, asb, rs, aop, rw, mw, pcw, ill, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the current cycle's state and controls, then advances a cycle.
    task automatic step(input string tag, input logic [3:0] st,
                        input logic [14:0] exp_ctrl);
        #1;
        check({tag, "_state"}, {28'd0, State}, {28'd0, st});
        check({tag, "_ctrl"}, {17'd0, ctrl}, {17'd0, exp_ctrl});
        tick();
    endtask

    localparam logic [14:0] C_FETCH   = 15'b0_1_00_10_10_00_0_0_1_0_0;
    localparam logic [14:0] C_FSTALL  = 15'b0_0_00_10_10_00_0_0_0_0_0;
    localparam logic [14:0] C_DECODE  = 15'b0_0_01_01_00_00_0_0_0_0_0;
    localparam logic [14:0] C_MEMADR  = 15'b0_0_10_01_00_00_0_0_0_0_0;
    localparam logic [14:0] C_MEMRD   = 15'b1_0_00_00_00_00_0_0_0_0_0;
    localparam logic [14:0] C_MEMWB   = 15'b0_0_00_00_01_00_1_0_0_0_1;
    localparam logic [14:0] C_MEMWRS  = 15'b1_0_00_00_00_00_0_1_0_0_0;
    localparam logic [14:0] C_MEMWR   = 15'b1_0_00_00_00_00_0_1_0_0_1;
    localparam logic [14:0] C_EXECR   = 15'b0_0_10_00_00_11_0_0_0_0_0;
    localparam logic [14:0] C_ALUWB   = 15'b0_0_00_00_00_00_1_0_0_0_1;
    localparam logic [14:0] C_EXECI   = 15'b0_0_10_01_00_11_0_0_0_0_0;
    localparam logic [14:0] C_JAL     = 15'b0_0_01_10_00_00_0_0_1_0_0;
    localparam logic [14:0] C_BEQ_T   = 15'b0_0_10_00_00_01_0_0_1_0_1;
    localparam logic [14:0] C_BEQ_NT  = 15'b0_0_10_00_00_01_0_0_0_0_1;
    localparam logic [14:0] C_ILLEGAL = 15'b0_0_01_01_00_00_0_0_0_1_1;

    initial begin
        reset    = 1'b1;
        op       = 7'b0000000;
        Zero     = 1'b0;
        MemReady = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state: Fetch, with fetch strobes following MemReady.
        MemReady = 1'b0;
        #1;
        check("rst_state", {28'd0, State}, 32'd0);
        check("rst_ctrl_nomr", {17'd0, ctrl},
              {17'd0, c(0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0)});
        MemReady = 1'b1;
        step("rst", 4'd0, C_FETCH);

        // R-type: 0,1,6,7 then back to 0.
        op = 7'b0110011;
        step("r_s1", 4'd1, C_DECODE);
        step("r_s6", 4'd6, C_EXECR);
        step("r_s7", 4'd7, C_ALUWB);

        // lw: two fetch stalls, three S3 stalls -> 10 cycles.
        op = 7'b0000011;
        MemReady = 1'b0;
        step("lw_f0", 4'd0, C_FSTALL);
        step("lw_f1", 4'd0, C_FSTALL);
        MemReady = 1'b1;
        step("lw_f2", 4'd0, C_FETCH);
        step("lw_s1", 4'd1, C_DECODE);
        step("lw_s2", 4'd2, C_MEMADR);
        MemReady = 1'b0;
        step("lw_s3a", 4'd3, C_MEMRD);
        step("lw_s3b", 4'd3, C_MEMRD);
        step("lw_s3c", 4'd3, C_MEMRD);
        MemReady = 1'b1;
        step("lw_s3d", 4'd3, C_MEMRD);
        step("lw_s4", 4'd4, C_MEMWB);

        // sw: MemWrite held across two stall cycles, done on release.
        op = 7'b0100011;
        step("sw_s0", 4'd0, C_FETCH);
        step("sw_s1", 4'd1, C_DECODE);
        step("sw_s2", 4'd2, C_MEMADR);
        MemReady = 1'b0;
        step("sw_s5a", 4'd5, C_MEMWRS);
        step("sw_s5b", 4'd5, C_MEMWRS);
        MemReady = 1'b1;
        step("sw_s5c", 4'd5, C_MEMWR);

        // beq taken then not taken.
        op = 7'b1100011;
        Zero = 1'b1;
        step("beq1_s0", 4'd0, C_FETCH);
        step("beq1_s1", 4'd1, C_DECODE);
        step("beq1_s10", 4'd10, C_BEQ_T);
        Zero = 1'b0;
        step("beq0_s0", 4'd0, C_FETCH);
        step("beq0_s1", 4'd1, C_DECODE);
        step("beq0_s10", 4'd10, C_BEQ_NT);

        // jal.
        op = 7'b1101111;
        step("jal_s0", 4'd0, C_FETCH);
        step("jal_s1", 4'd1, C_DECODE);
        step("jal_s9", 4'd9, C_JAL);
        step("jal_s7", 4'd7, C_ALUWB);

        // I-type ALU.
        op = 7'b0010011;
        step("i_s0", 4'd0, C_FETCH);
        step("i_s1", 4'd1, C_DECODE);
        step("i_s8", 4'd8, C_EXECI);
        step("i_s7", 4'd7, C_ALUWB);

        // Illegal opcode: pulse in S1, back to Fetch.
        op = 7'b1111111;
        step("ill_s0", 4'd0, C_FETCH);
        step("ill_s1", 4'd1, C_ILLEGAL);
        step("ill_back", 4'd0, C_FETCH);

        // The fetch above started an instruction; make it an sw and reset
        // it while stalled in S5.
        op = 7'b0100011;
        step("rsw_s1", 4'd1, C_DECODE);
        step("rsw_s2", 4'd2, C_MEMADR);
        MemReady = 1'b0;
        reset = 1'b1;
        step("rsw_s5", 4'd5, C_MEMWRS);
        reset = 1'b0;
        step("rsw_after", 4'd0, C_FSTALL);
        step("rsw_hold", 4'd0, C_FSTALL);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mainfsm.md
# mainfsm

Multicycle RISC-V main control FSM. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives datapath mux selects, register and memory write enables, and the 2-bit `ALUOp` consumed by the ALU decoder. It sits between the instruction register's opcode field and the `aludecoder`/datapath, and adds a memory-ready stall handshake.

## Interface
- `MEMWAIT_EN`, 1: when 1, `MemReady` stalls memory states; when 0, `MemReady` is ignored (treated as 1).

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; forces state to Fetch
- `op`  in  7  opcode `instr[6:0]` from instruction register
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory access completes this cycle
- `State`  out  4  current state encoding (debug)
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result
- `IRWrite`  out  1  load instruction register
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = 4
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = ReadData, 10 = ALUResult
- `ALUOp`  out  2  to `aludecoder`: 00 = add, 01 = sub, 11 = funct decode
- `RegWrite`  out  1  register file write
- `MemWrite`  out  1  data memory write
- `PCWrite`  out  1  PC load, `= PCUpdate | (Branch & Zero)`
- `IllegalOp`  out  1  one-cycle pulse on unsupported opcode
- `InstrDone`  out  1  one-cycle pulse on the final cycle of each instruction

## Operation
- Opcodes: lw `0000011`, sw `0100011`, R `0110011`, I-ALU `0010011`, beq `1100011`, jal `1101111`.
- States and encodings: S0 Fetch, S1 Decode, S2 MemAdr, S3 MemRead, S4 MemWB, S5 MemWrite, S6 ExecuteR, S7 ALUWB, S8 ExecuteI, S9 JAL, S10 BEQ (encodings 0–10). Codes 11–15 are unreachable and go to S0.
- Transitions:
  - S0 → S1 when `MemReady`, else hold.
  - S1 → S2 on lw/sw; S6 on R; S8 on I-ALU; S9 on jal; S10 on beq.
  - S1 → S0 on any other opcode, with `IllegalOp = 1` and `InstrDone = 1` that cycle.
  - S2 → S3 on lw, S5 otherwise.
  - S3 → S4 when `MemReady`, else hold.
  - S4 → S0.
  - S5 → S0 when `MemReady`, else hold.
  - S6 → S7; S8 → S7; S9 → S7; S7 → S0; S10 → S0.
- Outputs not listed for a state are 0 (no x). Per-state outputs:
  - S0: `ALUSrcB` = 10, `ResultSrc` = 10; `IRWrite` and `PCUpdate` = `MemReady`.
  - S1: `ALUSrcA` = 01, `ALUSrcB` = 01.
  - S2: `ALUSrcA` = 10, `ALUSrcB` = 01.
  - S3: `AdrSrc` = 1.
  - S4: `ResultSrc` = 01, `RegWrite` = 1.
  - S5: `AdrSrc` = 1, `MemWrite` = 1 for every cycle in S5.
  - S6: `ALUSrcA` = 10, `ALUOp` = 11.
  - S7: `RegWrite` = 1.
  - S8: `ALUSrcA` = 10, `ALUSrcB` = 01, `ALUOp` = 11.
  - S9: `ALUSrcA` = 01, `ALUSrcB` = 10, `PCUpdate` = 1.
  - S10: `ALUSrcA` = 10, `ALUOp` = 01, `Branch` = 1.
- `InstrDone` = 1 in:
  - S4, S7, S10;
  - S5 when `MemReady`;
  - S1 on an illegal opcode.
- `op` is sampled only in S1 and S2; `IRWrite` fires only in S0, so `op` is stable across an instruction.

## Timing
- `State` is registered. All outputs are Moore decodes of `State`, except these combinational terms: `IRWrite`, `PCWrite` (`PCUpdate` / `Zero`), the S5 `InstrDone`, and `IllegalOp`.
- Reset:
  - `reset` sampled high → next cycle `State` = 0.
  - Outputs then equal S0 values: `ALUSrcB` = 10, `ResultSrc` = 10, all others 0 except `IRWrite`/`PCWrite` = `MemReady`.
  - Reset mid-instruction (including during a stall) aborts with no further `RegWrite`/`MemWrite`.
- Latency with `MemReady` held 1:
  - lw: 5 cycles.
  - sw, R, I, jal: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each stall cycle in S0, S3 or S5 adds exactly one cycle. `IRWrite`/`PCWrite` assert exactly once per fetch.
- beq: `PCWrite` in S10 equals `Zero` that cycle.

## Test plan
- Reset, then `MemReady` = 1 and `op` = `0110011` → `State` sequence 0,1,6,7,0; `ALUOp` = 11 in S6; `RegWrite` = 1 and `InstrDone` = 1 only in S7.
- lw with `MemReady` low for 2 cycles in S0 and 3 cycles in S3 → `IRWrite` pulses once, on the release cycle; S3 lasts 4 cycles with `AdrSrc` = 1; `RegWrite` = 1 in S4; 10 cycles total.
- sw → `MemWrite` = 1 throughout S5 including stalls; `InstrDone` only on the `MemReady` cycle; `RegWrite` never asserts.
- beq with `Zero` = 1, then again with `Zero` = 0 → `ALUOp` = 01 in S10 both times; `PCWrite` = 1 for `Zero` = 1 and 0 for `Zero` = 0.
- jal → S9 asserts `PCWrite` = 1 with `ALUSrcA` = 01, `ALUSrcB` = 10; S7 asserts `RegWrite` = 1; illegal `op` = `1111111` → `IllegalOp` pulse in S1, then back to S0.
- `reset` asserted in S5 while `MemReady` = 0 → next cycle `State` = 0 and `MemWrite` = 0.
